// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Read data returned to a requester whose transaction was abandoned by the watchdog.
    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // (cur + step) mod n, valid for cur < n and step <= n, so no divider is needed.
    function automatic int unsigned arb_wrap_next(input int unsigned cur,
                                                  input int unsigned step,
                                                  input int unsigned n);
        int unsigned sum;
        sum = cur + step;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_i+1 (wrapping), with last_i itself checked last.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] win_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Scan farthest-first so the closest requester after last_i overwrites and wins.
    always_comb begin
        win_o = last_i;
        any_o = |req_i;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'(arb_wrap_next(32'(last_i), unsigned'(k), N));
            if (req_i[cand]) begin
                win_o = cand;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port among NUM_REQ
// requesters, one outstanding downstream transaction at a time.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a BUSY phase that sees
// no m_ready for TIMEOUT_CYCLES cycles (returns 32'hDEAD_BEEF, pulses timeout_err).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned IDX_W          = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     s_valid,
    output logic [NUM_REQ-1:0]     s_ready,
    input  logic [32*NUM_REQ-1:0]  s_addr,
    input  logic [32*NUM_REQ-1:0]  s_wdata,
    input  logic [4*NUM_REQ-1:0]   s_wstrb,
    output logic [31:0]            s_rdata,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_addr,
    output logic [31:0]            m_wdata,
    output logic [3:0]             m_wstrb,
    input  logic [31:0]            m_rdata,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   busy,
    output logic                   timeout_err
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] pick_win;
    logic             pick_any;
    logic             tmo;
    logic             done;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (s_valid),
        .last_i (grant_q),
        .win_o  (pick_win),
        .any_o  (pick_any)
    );

    assign busy      = (state_q == ARB_BUSY);
    assign m_valid   = busy;
    assign grant_idx = grant_q;
    assign done      = busy && (m_ready || tmo);

    // The granted requester's slice drives the downstream port directly.
    assign m_addr  = s_addr [32*grant_q +: 32];
    assign m_wdata = s_wdata[32*grant_q +: 32];
    assign m_wstrb = s_wstrb[4*grant_q  +: 4];

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // A real m_ready in the last allowed cycle beats the watchdog.
    assign tmo         = busy && !m_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo;
    assign s_rdata     = tmo ? ARB_TIMEOUT_RDATA : m_rdata;

    // Watchdog counter: held at zero in IDLE, counts BUSY cycles without m_ready.
    always_ff @(posedge clk) begin
        if (reset || state_q == ARB_IDLE) begin
            cnt_q <= '0;
        end else if (!m_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo                   = 1'b0;
    assign timeout_err           = 1'b0;
    assign s_rdata               = m_rdata;
`endif

    // Completion pulse goes only to the granted requester, in the m_ready cycle.
    always_comb begin
        s_ready = '0;
        if (done) begin
            s_ready[grant_q] = 1'b1;
        end
    end

    // Arbitration FSM: grant in IDLE, hold the grant until completion in BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_win;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (done) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_mem_bus_arbiter;

    localparam int NUM_REQ = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    s_valid;
    logic [NUM_REQ-1:0]    s_ready;
    logic [32*NUM_REQ-1:0] s_addr;
    logic [32*NUM_REQ-1:0] s_wdata;
    logic [4*NUM_REQ-1:0]  s_wstrb;
    logic [31:0]           s_rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [31:0]           m_addr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_wstrb;
    logic [31:0]           m_rdata;
    logic [0:0]            grant_idx;
    logic                  busy;
    logic                  timeout_err;

    mem_bus_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_rdata     (m_rdata),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          tmo;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;

    logic [31:0] mem [logic [31:0]];
    bit          mem_auto = 1'b1;
    int          mem_lat  = 1;
    int          mcnt     = 0;
    logic [31:0] mword;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int unsigned idx, input logic [31:0] rdata, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb, input bit tmo);
        exp_t e;
        e.idx = idx; e.rdata = rdata; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // Returns at the edge following the completion cycle that reaches target.
    task automatic wait_done(input int target, input int budget, input string name);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (done_cnt >= target) break;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s: completions %0d expected %0d (wait expired)", name, done_cnt, target);
        end
    endtask

    task automatic set_slice(input int unsigned idx, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        s_addr [32*idx +: 32] = addr;
        s_wdata[32*idx +: 32] = wdata;
        s_wstrb[4*idx  +: 4]  = wstrb;
    endtask

    task automatic do_req(input int unsigned idx, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rd, input string name);
        int start;
        push_exp(idx, exp_rd, addr, wdata, wstrb, 1'b0);
        @(posedge clk); #1;
        set_slice(idx, addr, wdata, wstrb);
        start = done_cnt;
        s_valid[idx] = 1'b1;
        wait_done(start + 1, 60, name);
        #1;
        s_valid[idx] = 1'b0;
    endtask

    // Native-protocol memory: asserts m_ready mem_lat cycles after m_valid rises.
    always @(posedge clk) begin
        #1;
        if (mem_auto) begin
            if (m_ready) begin
                m_ready = 1'b0;
                mcnt    = 0;
            end else if (m_valid) begin
                if (mcnt >= mem_lat) begin
                    if (m_wstrb != 4'b0000) begin
                        mword = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (m_wstrb[b]) mword[8*b +: 8] = m_wdata[8*b +: 8];
                        end
                        mem[m_addr] = mword;
                        m_rdata     = 32'h0;
                    end else begin
                        m_rdata = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
                    end
                    m_ready = 1'b1;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    // Monitor: every completion pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (|s_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_s_ready", 32'(s_ready), 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("s_ready_onehot", 32'(s_ready), 32'(1) << mon_e.idx);
                check("grant_idx",      32'(grant_idx), mon_e.idx);
                check("s_rdata",        s_rdata, mon_e.rdata);
                check("timeout_err",    32'(timeout_err), 32'(mon_e.tmo));
                check("m_addr",         m_addr, mon_e.addr);
                check("m_wdata",        m_wdata, mon_e.wdata);
                check("m_wstrb",        32'(m_wstrb), 32'(mon_e.wstrb));
            end
            done_cnt++;
        end else if (timeout_err) begin
            check("stray_timeout_err", 32'(timeout_err), 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int start;
        reset   = 1'b1;
        s_valid = '0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        m_ready = 1'b0;
        m_rdata = 32'h0;
        mem[32'h100] = 32'h1234_5678;
        mem[32'h200] = 32'h1122_3344;
        mem[32'h400] = 32'hA0A0_0000;
        mem[32'h500] = 32'hB1B1_1111;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",        32'(busy), 32'h0);
        check("rst_m_valid",     32'(m_valid), 32'h0);
        check("rst_s_ready",     32'(s_ready), 32'h0);
        check("rst_grant_idx",   32'(grant_idx), 32'h1);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single request with latency checks: request in cycle N
        push_exp(0, 32'h1234_5678, 32'h100, 32'h0, 4'h0, 1'b0);
        set_slice(0, 32'h100, 32'h0, 4'h0);
        set_slice(1, 32'h0DD0_0DD0, 32'h5555_AAAA, 4'hF);
        s_valid = 2'b01;
        @(negedge clk);
        check("lat_N_m_valid",   32'(m_valid), 32'h0);
        @(negedge clk);
        check("lat_N1_m_valid",  32'(m_valid), 32'h1);
        check("lat_N1_s_ready",  32'(s_ready), 32'h0);
        @(negedge clk);
        check("lat_N2_s_ready",  32'(s_ready), 32'h1);
        @(posedge clk); #1;
        s_valid = 2'b00;
        @(negedge clk);
        check("post_m_valid",    32'(m_valid), 32'h0);

        // Write path from requester 1, then read back through requester 0
        do_req(1, 32'h200, 32'hCAFE_F00D, 4'b0011, 32'h0, "write_r1");
        check("mem_after_write", mem[32'h200], 32'h1122_F00D);
        do_req(0, 32'h200, 32'h0, 4'h0, 32'h1122_F00D, "readback_r0");

        // Contention after a fresh reset: grants must alternate 0,1,0,1,0,1
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_slice(0, 32'h400, 32'h0, 4'h0);
        set_slice(1, 32'h500, 32'h0, 4'h0);
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0) push_exp(0, 32'hA0A0_0000, 32'h400, 32'h0, 4'h0, 1'b0);
            else            push_exp(1, 32'hB1B1_1111, 32'h500, 32'h0, 4'h0, 1'b0);
        end
        start   = done_cnt;
        s_valid = 2'b11;
        wait_done(start + 6, 200, "contention");
        #1;
        s_valid = 2'b00;

        // Reset during BUSY, then a late m_ready
        @(posedge clk); #1;
        mem_auto = 1'b0;
        m_ready  = 1'b0;
        set_slice(0, 32'h300, 32'h0, 4'h0);
        s_valid  = 2'b01;
        @(posedge clk); #1;
        check("midop_busy", 32'(m_valid), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        s_valid = 2'b00;
        m_ready = 1'b1;
        m_rdata = 32'h7777_7777;
        @(negedge clk);
        check("midop_s_ready",   32'(s_ready), 32'h0);
        check("midop_idle",      32'(busy), 32'h0);
        check("midop_m_valid",   32'(m_valid), 32'h0);
        check("midop_grant_idx", 32'(grant_idx), 32'h1);
        @(posedge clk); #1;
        m_ready  = 1'b0;
        mcnt     = 0;
        mem_auto = 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog abort after 8 BUSY cycles
        mem_auto = 1'b0;
        push_exp(0, 32'hDEAD_BEEF, 32'h300, 32'h0, 4'h0, 1'b1);
        @(posedge clk); #1;
        s_valid = 2'b01;
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) nb++;
            if (|s_ready) break;
        end
        check("tmo_busy_cycles", 32'(nb), 32'd8);
        @(posedge clk); #1;
        s_valid = 2'b00;
        check("tmo_m_valid_after", 32'(m_valid), 32'h0);

        // m_ready on the timeout cycle: real data wins
        push_exp(0, 32'h5A5A_A5A5, 32'h300, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        s_valid = 2'b01;
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (busy) nb++;
            if (nb == 8) begin
                m_ready = 1'b1;
                m_rdata = 32'h5A5A_A5A5;
                break;
            end
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        s_valid = 2'b00;
        check("race_idle_after", 32'(busy), 32'h0);
        mcnt     = 0;
        mem_auto = 1'b1;
`else
        // Long stall: without the watchdog BUSY simply waits
        mem_lat = 12;
        do_req(1, 32'h400, 32'h0, 4'h0, 32'hA0A0_0000, "long_stall");
        mem_lat = 1;
`endif

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Round-robin arbiter that shares one picorv32 native memory port (valid/ready, addr/wdata/wstrb/rdata) between NUM_REQ requesters.
- Typical use: CPU core plus a DMA/loader master in front of the single-port memory model.
- Upstream ports are native-protocol slaves; the downstream port is a native-protocol master.
- At most one transaction is outstanding downstream at a time.

Parameters:
- NUM_REQ, 2: number of requesters, range 2..8.
- IDX_W, $clog2(NUM_REQ): grant index width (derived; do not override).
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  NUM_REQ  per-requester request.
- s_ready  out  NUM_REQ  per-requester completion pulse.
- s_addr  in  32*NUM_REQ  requester i at [32*i+:32].
- s_wdata  in  32*NUM_REQ  write data, same packing as s_addr.
- s_wstrb  in  4*NUM_REQ  byte strobes; all zero means read.
- s_rdata  out  32  shared read data; valid only with the matching s_ready bit.
- m_valid  out  1  downstream request.
- m_ready  in  1  downstream completion.
- m_addr  out  32  downstream address.
- m_wdata  out  32  downstream write data.
- m_wstrb  out  4  downstream byte strobes.
- m_rdata  in  32  downstream read data.
- grant_idx  out  IDX_W  index of the current or last granted requester.
- busy  out  1  high while in BUSY.
- timeout_err  out  1  one-cycle error pulse; tied 0 without the feature.

Behaviour:
- State machine with two states, IDLE and BUSY.
- Reset: state=IDLE, grant_idx=NUM_REQ-1 (so requester 0 wins first), m_valid=0, s_ready=0, busy=0, timeout_err=0.
- IDLE:
  - If any s_valid bit is set, select the first set bit searching upward from grant_idx+1 modulo NUM_REQ.
  - Register the winner into grant_idx and go to BUSY next cycle.
  - If no s_valid bit is set, stay in IDLE.
- BUSY:
  - m_valid=1.
  - m_addr, m_wdata and m_wstrb are combinational from the granted requester's slice.
  - Requesters hold their request stable until ready, per the native protocol.
- Completion in BUSY:
  - When m_ready=1, drive s_ready[grant_idx]=1 and s_rdata=m_rdata in the same cycle (combinational), then return to IDLE.
  - m_valid is 0 in the following cycle.
- Latency:
  - Request at cycle N → m_valid at N+1.
  - Zero-wait memory gives m_ready and s_ready at N+2.
  - Minimum 1 dead IDLE cycle between grants.
- Outputs outside BUSY: s_ready is all-zero and m_valid=0. m_ready seen outside BUSY is ignored.
- s_rdata is a don't-care unless some s_ready bit is set; drive m_rdata unconditionally.
- Simultaneous requests: round-robin strictly alternates. A requester that keeps s_valid high can never win twice in a row while another requester is waiting.
- Requester drops s_valid while granted: this is a protocol violation. The transaction still completes downstream and s_ready is still pulsed.
- Reset mid-transaction: return to IDLE immediately and drop m_valid. A late m_ready is ignored.
- busy = (state == BUSY).

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without m_ready.
  - When it reaches TIMEOUT_CYCLES-1 without m_ready: pulse timeout_err for 1 cycle, drive s_ready[grant_idx]=1 with s_rdata=32'hDEAD_BEEF, drop m_valid, go to IDLE.
  - If m_ready arrives in the same cycle as the timeout, the real response wins and timeout_err stays 0.
- Undefined: no counter exists, timeout_err is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {ARB_IDLE, ARB_BUSY};
  - the constant ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;
  - the helper function for a next-index-modulo-N wrap.
- One sub-module, rr_pick: purely combinational.
  - Inputs: request vector and last grant.
  - Outputs: winner index and an any-request flag.
  - Reusable by future arbiters.

Test Plan:
- Single request: reset, then s_valid=2'b01, s_addr[0]=0x100, single-cycle memory returning 0x1234_5678 → m_valid at N+1; s_ready=2'b01 and s_rdata=0x1234_5678 at N+2; grant_idx=0.
- Contention: both requesters valid continuously for 6 transactions → grant order 0,1,0,1,0,1; never two consecutive grants to the same requester.
- Write path: requester 1 writes addr 0x200, wdata 0xCAFEF00D, wstrb 4'b0011 → m_addr, m_wdata and m_wstrb match requester 1 while m_valid; the memory model shows bytes [15:0]=0xF00D updated and the upper bytes unchanged.
- Reset mid-op: assert reset in the BUSY cycle, then raise m_ready in the next cycle → no s_ready pulse; state IDLE; grant_idx=NUM_REQ-1.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): m_ready held 0 → after 8 BUSY cycles, timeout_err=1 for 1 cycle, s_ready[0]=1, s_rdata=0xDEADBEEF, m_valid=0 next cycle.
- Timeout race: m_ready=1 exactly on the timeout cycle → real m_rdata is returned and timeout_err=0.
